// File: rtl/logic_vec_driver_checker_pkg.sv
// Shared types and helpers for the 4-input logic cell driver/checker.
package logic_vec_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StDrain = 2'd2,
        StFin   = 2'd3
    } state_e;

    // Number of distinct stimulus vectors in one pass.
    localparam int unsigned VEC_NUM = 16;

    // Reference function of the cell under test: y = (a&b) | (c^d), vec = {a,b,c,d}.
    function automatic logic exp_y(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] ^ v[0]);
    endfunction

    // 4-bit binary to Gray conversion.
    function automatic logic [3:0] gray4(input logic [3:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/logic_vec_driver_checker_if.sv
// Bus between the driver/checker and the cell under test plus run control/status.
// master: the driver/checker side; slave: the cell/controller side.
interface logic_vec_driver_checker_if #(
    parameter int unsigned ERR_W = 8
);
    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             y_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        input  start,
        input  y_in,
        output a,
        output b,
        output c,
        output d,
        output busy,
        output done,
        output pass,
        output err_cnt
    );

    modport slave (
        output start,
        output y_in,
        input  a,
        input  b,
        input  c,
        input  d,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt
    );
endinterface

// File: rtl/logic_vec_driver_checker_exp_delay_line.sv
// Delay line carrying {valid, expected y} alongside the cell's latency.
// LATENCY=0 is a pure pass-through.
module exp_delay_line #(
    parameter int unsigned LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_exp,
    output logic tap_valid,
    output logic tap_exp
);

    if (LATENCY == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign tap_valid      = in_valid;
        assign tap_exp        = in_exp;
    end else begin : g_pipe
        logic [LATENCY-1:0] valid_q, valid_d;
        logic [LATENCY-1:0] exp_q, exp_d;

        // Shift one stage per cycle; the newest entry enters at bit 0.
        always_comb begin
            valid_d = (valid_q << 1) | LATENCY'(in_valid);
            exp_d   = (exp_q << 1) | LATENCY'(in_exp);
        end

        // Pipe registers; reset clears every valid bit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= '0;
                exp_q   <= '0;
            end else begin
                valid_q <= valid_d;
                exp_q   <= exp_d;
            end
        end

        assign tap_valid = valid_q[LATENCY-1];
        assign tap_exp   = exp_q[LATENCY-1];
    end

endmodule

// File: rtl/logic_vec_driver_checker.sv
// Self-checking stimulus source for the y = (a&b) | (c^d) cell.
// Drives all 16 input vectors LOOPS times, compares y_in LATENCY cycles later and
// reports a saturating mismatch count with done/pass flags.
// Optional macro GRAY_ORDER_EN: drive vectors in 4-bit Gray order instead of binary.
module logic_vec_driver_checker
    import logic_vec_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned LOOPS   = 1,
    parameter int unsigned ERR_W   = 8
) (
    input logic                        clk,
    input logic                        rst_n,
    logic_vec_driver_checker_if.master bus
);

    localparam logic [3:0] LAST_VEC   = 4'(VEC_NUM - 1);
    localparam logic [7:0] LAST_LOOP  = 8'(LOOPS - 1);
    localparam logic [2:0] LAST_DRAIN = 3'(LATENCY - 1);

    function automatic logic [3:0] drive_order(input logic [3:0] v);
`ifdef GRAY_ORDER_EN
        return gray4(v);
`else
        return v;
`endif
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       vec_cnt_q, vec_cnt_d;
    logic [7:0]       loop_cnt_q, loop_cnt_d;
    logic [2:0]       drain_cnt_q, drain_cnt_d;
    logic [3:0]       vec_q, vec_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             pass_q, pass_d;

    logic tap_valid;
    logic tap_exp;

    // Only vectors driven while in DRIVE are ever compared.
    exp_delay_line #(
        .LATENCY (LATENCY)
    ) u_exp_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state_q == StDrive),
        .in_exp    (exp_y(vec_q)),
        .tap_valid (tap_valid),
        .tap_exp   (tap_exp)
    );

    // Next-state: compare at the tap, then sequence IDLE -> DRIVE -> DRAIN -> FIN.
    always_comb begin
        state_d     = state_q;
        vec_cnt_d   = vec_cnt_q;
        loop_cnt_d  = loop_cnt_q;
        drain_cnt_d = drain_cnt_q;
        vec_d       = vec_q;
        err_cnt_d   = err_cnt_q;
        pass_d      = pass_q;

        // Written as if/else so an unknown y_in lands in the mismatch branch.
        if (tap_valid) begin
            if (bus.y_in == tap_exp) begin
                err_cnt_d = err_cnt_q;
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StDrive;
                    vec_cnt_d  = '0;
                    loop_cnt_d = '0;
                    vec_d      = drive_order(4'd0);
                    err_cnt_d  = '0;
                    pass_d     = 1'b0;
                end
            end
            StDrive: begin
                if (vec_cnt_q == LAST_VEC && loop_cnt_q == LAST_LOOP) begin
                    if (LATENCY == 0) begin
                        state_d = StFin;
                        pass_d  = (err_cnt_d == '0);
                    end else begin
                        state_d     = StDrain;
                        drain_cnt_d = '0;
                    end
                end else begin
                    vec_cnt_d = vec_cnt_q + 4'd1;
                    if (vec_cnt_q == LAST_VEC) begin
                        loop_cnt_d = loop_cnt_q + 8'd1;
                    end
                    vec_d = drive_order(vec_cnt_d);
                end
            end
            StDrain: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    state_d = StFin;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vec_cnt_q   <= '0;
            loop_cnt_q  <= '0;
            drain_cnt_q <= '0;
            vec_q       <= '0;
            err_cnt_q   <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_cnt_q   <= vec_cnt_d;
            loop_cnt_q  <= loop_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            vec_q       <= vec_d;
            err_cnt_q   <= err_cnt_d;
            pass_q      <= pass_d;
        end
    end

    assign bus.a       = vec_q[3];
    assign bus.b       = vec_q[2];
    assign bus.c       = vec_q[1];
    assign bus.d       = vec_q[0];
    assign bus.busy    = (state_q == StDrive) || (state_q == StDrain);
    assign bus.done    = (state_q == StFin);
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_logic_vec_driver_checker.sv
// Bench for logic_vec_driver_checker: two instances (registered cell, LATENCY=2,
// and combinational cell, LATENCY=0 with 3-bit saturating count), each paired with
// a cell model whose response can be correct, stuck-0 or stuck-1.
`timescale 1ns/1ps
module tb_logic_vec_driver_checker;

    localparam int LAT_A   = 2;
    localparam int LOOPS_A = 1;
    localparam int ERRW_A  = 8;
    localparam int END_A   = 16 * LOOPS_A + LAT_A;
    localparam int LAT_B   = 0;
    localparam int LOOPS_B = 4;
    localparam int ERRW_B  = 3;
    localparam int END_B   = 16 * LOOPS_B + LAT_B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    logic start_a = 1'b0;
    logic start_b = 1'b0;
    int   mode_a = 0;  // 0: correct cell, 1: y stuck at 0, 2: y stuck at 1
    int   mode_b = 0;

    logic_vec_driver_checker_if #(.ERR_W(ERRW_A)) if_a ();
    logic_vec_driver_checker_if #(.ERR_W(ERRW_B)) if_b ();

    logic_vec_driver_checker #(
        .LATENCY (LAT_A),
        .LOOPS   (LOOPS_A),
        .ERR_W   (ERRW_A)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.master)
    );

    logic_vec_driver_checker #(
        .LATENCY (LAT_B),
        .LOOPS   (LOOPS_B),
        .ERR_W   (ERRW_B)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.master)
    );

    function automatic logic cell_y(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] ^ v[0]);
    endfunction

    function automatic logic [3:0] order4(input int k);
        logic [3:0] v;
        v = k[3:0];
`ifdef GRAY_ORDER_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    function automatic logic wrong(input logic [3:0] v, input int mode);
        if (mode == 1) return cell_y(v);
        if (mode == 2) return !cell_y(v);
        return 1'b0;
    endfunction

    // Mismatches whose compare cycle (k + lat) has completed before cycle n.
    function automatic int err_upto(input int n, input int lat, input int loops,
                                    input int mode, input int errmax);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 16 * loops; k++) begin
            if (k + lat + 1 <= n && wrong(order4(k % 16), mode)) cnt++;
        end
        return (cnt > errmax) ? errmax : cnt;
    endfunction

    // Expected outputs in the cycle following edge E0+n (n<0: never started / reset).
    task automatic model_out(input int n, input int lat, input int loops, input int mode,
                             input int errmax, output logic [3:0] vec, output logic busy,
                             output logic done, output logic pass, output int err);
        int endc;
        endc = 16 * loops + lat;
        if (n < 0) begin
            vec = 4'd0; busy = 1'b0; done = 1'b0; pass = 1'b0; err = 0;
        end else begin
            vec  = (n < 16 * loops) ? order4(n % 16) : order4(15);
            busy = (n < endc);
            done = (n == endc);
            err  = err_upto(n, lat, loops, mode, errmax);
            pass = (n >= endc) && (err == 0);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: actual %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Cell models: A is a two-stage registered cell, B is combinational.
    logic s1_a, s2_a;
    always @(posedge clk) begin
        s1_a <= cell_y({if_a.a, if_a.b, if_a.c, if_a.d});
        s2_a <= s1_a;
    end
    assign if_a.y_in  = (mode_a == 1) ? 1'b0 : (mode_a == 2) ? 1'b1 : s2_a;
    assign if_b.y_in  = (mode_b == 1) ? 1'b0 : (mode_b == 2) ? 1'b1 :
                        cell_y({if_b.a, if_b.b, if_b.c, if_b.d});
    assign if_a.start = start_a;
    assign if_b.start = start_b;

    // Run tracker: cycles since the accepting edge of the current/last run.
    int n_a = -1, n_b = -1;
    int run_mode_a = 0, run_mode_b = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_a <= -1; n_b <= -1; run_mode_a <= 0; run_mode_b <= 0;
        end else begin
            if ((n_a < 0 || n_a > END_A) && start_a) begin
                n_a <= 0; run_mode_a <= mode_a;
            end else if (n_a >= 0 && n_a <= END_A) begin
                n_a <= n_a + 1;
            end
            if ((n_b < 0 || n_b > END_B) && start_b) begin
                n_b <= 0; run_mode_b <= mode_b;
            end else if (n_b >= 0 && n_b <= END_B) begin
                n_b <= n_b + 1;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [3:0] ev;
        logic eb, ed, ep;
        int ee;
        if (chk_en) begin
            model_out(n_a, LAT_A, LOOPS_A, run_mode_a, 255, ev, eb, ed, ep, ee);
            check("a_vec", {28'd0, if_a.a, if_a.b, if_a.c, if_a.d}, {28'd0, ev});
            check("a_busy", {31'd0, if_a.busy}, {31'd0, eb});
            check("a_done", {31'd0, if_a.done}, {31'd0, ed});
            check("a_pass", {31'd0, if_a.pass}, {31'd0, ep});
            check("a_err_cnt", {24'd0, if_a.err_cnt}, ee);
            model_out(n_b, LAT_B, LOOPS_B, run_mode_b, 7, ev, eb, ed, ep, ee);
            check("b_vec", {28'd0, if_b.a, if_b.b, if_b.c, if_b.d}, {28'd0, ev});
            check("b_busy", {31'd0, if_b.busy}, {31'd0, eb});
            check("b_done", {31'd0, if_b.done}, {31'd0, ed});
            check("b_pass", {31'd0, if_b.pass}, {31'd0, ep});
            check("b_err_cnt", {29'd0, if_b.err_cnt}, ee);
        end
    end

    // Pulse start on A from posedge+1, return edges from E0 until done is seen.
    task automatic run_a(input int mode, output int edges);
        @(posedge clk); #1;
        mode_a  = mode;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        edges = 0;
        while (if_a.done !== 1'b1 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        check("a_done_seen", {31'd0, if_a.done}, 32'd1);
    endtask

    initial begin
        int edges, dones, done_at, done_at2;
        logic [15:0] table_bits;

        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pin the model against hand-derived truth table and counts.
        for (int v = 0; v < 16; v++) table_bits[v] = cell_y(v[3:0]);
        check("model_truth_table", {16'd0, table_bits}, 32'h0000_F666);
        check("model_stuck0_count", err_upto(1000, 0, 1, 1, 255), 32'd10);
        check("model_stuck1_count", err_upto(1000, 0, 1, 2, 255), 32'd6);

        // A: correct cell.
        run_a(0, edges);
        check("a_ok_done_cycle", edges, 32'd18);
        check("a_ok_pass", {31'd0, if_a.pass}, 32'd1);
        check("a_ok_err", {24'd0, if_a.err_cnt}, 32'd0);

        // A: y stuck at 0.
        run_a(1, edges);
        check("a_s0_done_cycle", edges, 32'd18);
        check("a_s0_pass", {31'd0, if_a.pass}, 32'd0);
        check("a_s0_err", {24'd0, if_a.err_cnt}, 32'd10);

        // B: y stuck at 1, saturating 3-bit count; start pulses while busy ignored.
        @(posedge clk); #1;
        mode_b = 2; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        edges = 0; dones = 0; done_at = -1;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            start_b = (edges == 10 || edges == 30) ? 1'b1 : 1'b0;
            if (if_b.done === 1'b1) begin
                dones++;
                if (dones == 1) done_at = edges;
            end
        end
        check("b_s1_done_count", dones, 32'd1);
        check("b_s1_done_cycle", done_at, 32'd64);
        check("b_s1_err", {29'd0, if_b.err_cnt}, 32'd7);
        check("b_s1_pass", {31'd0, if_b.pass}, 32'd0);

        // B: correct cell, start held through FIN -> back-to-back run.
        mode_b = 0; start_b = 1'b1;
        @(posedge clk); #1;
        edges = 0; dones = 0; done_at = -1; done_at2 = -1;
        while (edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 70) start_b = 1'b0;
            if (if_b.done === 1'b1) begin
                dones++;
                if (dones == 1) done_at = edges;
                if (dones == 2) done_at2 = edges;
            end
        end
        check("b_hold_done_count", dones, 32'd2);
        check("b_hold_done1", done_at, 32'd64);
        check("b_hold_done2", done_at2, 32'd130);
        check("b_hold_pass", {31'd0, if_b.pass}, 32'd1);

        // A: reset while vector 7 is driven, then a clean run.
        @(posedge clk); #1;
        mode_a = 0; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_abcd", {28'd0, if_a.a, if_a.b, if_a.c, if_a.d}, 32'd0);
        check("rst_busy", {31'd0, if_a.busy}, 32'd0);
        check("rst_done", {31'd0, if_a.done}, 32'd0);
        check("rst_err", {24'd0, if_a.err_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (if_a.done === 1'b1) dones++;
        end
        check("rst_no_done", dones, 32'd0);
        run_a(0, edges);
        check("a_after_rst_done_cycle", edges, 32'd18);
        check("a_after_rst_pass", {31'd0, if_a.pass}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
